// File: rtl/safe_lock_controller.sv
// Keypad safe sequencer: code entry, comparison against a reprogrammable stored code,
// timed unlock and failed-attempt lockout. Keys are registered once before the FSM sees them.
module safe_lock_controller #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    UNLOCK_CYCLES  = 500,
    parameter int                    LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    output logic       unlock,
    output logic       locked_out,
    output logic       error_pulse,
    output logic       prog_done,
    output logic [2:0] state_out,
    output logic [2:0] digit_count
);
    localparam int CW   = CODE_LEN * 4;
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int FW   = $clog2(MAX_FAILS + 1);

    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_LIMIT   = FW'(MAX_FAILS);
    localparam logic [2:0]    FULL_COUNT   = 3'(CODE_LEN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_PROG    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    state_e        r_state, w_state_nxt;
    logic [3:0]    r_key;
    logic [CW-1:0] r_buf, w_buf_nxt, w_cap_buf;
    logic [CW-1:0] r_code, w_code_nxt;
    logic [2:0]    r_count, w_count_nxt, w_cap_count;
    logic          r_ovf, w_ovf_nxt, w_cap_ovf;
    logic [FW-1:0] r_fails, w_fails_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          r_unlock, r_locked_out, r_err, r_done;
    logic          w_err_nxt, w_done_nxt;
    logic          w_is_digit, w_is_hash, w_is_star, w_match, w_prog_ok;

    assign w_is_digit = (r_key <= 4'd9);
    assign w_is_hash  = (r_key == 4'd10);
    assign w_is_star  = (r_key == 4'd11);
    assign w_prog_ok  = (r_count == FULL_COUNT) && !r_ovf;
    assign w_match    = w_prog_ok && (r_buf == r_code);

    // Result of accepting r_key as the next digit; shared by ENTRY, IDLE and PROG.
    always_comb begin
        w_cap_buf   = r_buf;
        w_cap_count = r_count;
        w_cap_ovf   = r_ovf;
        if (r_count < FULL_COUNT) begin
            for (int s = 0; s < CODE_LEN; s++) begin
                if (r_count == 3'(s)) w_cap_buf[(CODE_LEN-1-s)*4 +: 4] = r_key;
            end
            w_cap_count = r_count + 3'd1;
        end else begin
            w_cap_ovf = 1'b1;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_code_nxt  = r_code;
        w_fails_nxt = r_fails;
        w_timer_nxt = r_timer;
        w_err_nxt   = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_is_digit) begin
                    w_buf_nxt   = w_cap_buf;
                    w_count_nxt = w_cap_count;
                    w_ovf_nxt   = w_cap_ovf;
                    w_state_nxt = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (w_is_digit) begin
                    w_buf_nxt   = w_cap_buf;
                    w_count_nxt = w_cap_count;
                    w_ovf_nxt   = w_cap_ovf;
                end else if (w_is_star) begin
                    w_buf_nxt   = '0;
                    w_count_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (w_is_hash) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_buf_nxt   = '0;
                w_count_nxt = '0;
                w_ovf_nxt   = 1'b0;
                if (w_match) begin
                    w_fails_nxt = '0;
                    w_timer_nxt = UNLOCK_LOAD;
                    w_state_nxt = ST_OPEN;
                end else begin
                    w_err_nxt = 1'b1;
                    if (r_fails < FAIL_LIMIT) w_fails_nxt = r_fails + FW'(1);
                    if (r_fails >= FAIL_LIMIT - FW'(1)) begin
                        w_timer_nxt = LOCKOUT_LOAD;
                        w_state_nxt = ST_LOCKOUT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OPEN: begin
                // Expiry takes priority over any key presented in the same cycle.
                if (r_timer == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                    if (w_is_hash) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_is_star) begin
                        w_buf_nxt   = '0;
                        w_count_nxt = '0;
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = ST_PROG;
                    end
                end
            end
            ST_PROG: begin
                if (w_is_digit) begin
                    w_buf_nxt   = w_cap_buf;
                    w_count_nxt = w_cap_count;
                    w_ovf_nxt   = w_cap_ovf;
                end else if (w_is_hash || w_is_star) begin
                    w_buf_nxt   = '0;
                    w_count_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                    if (w_is_hash && w_prog_ok) begin
                        w_code_nxt  = r_buf;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_err_nxt   = w_is_hash;
                        w_timer_nxt = UNLOCK_LOAD;
                        w_state_nxt = ST_OPEN;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_fails_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_buf_nxt   = '0;
                w_count_nxt = '0;
                w_ovf_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: the stored code is a state register with a reset value, so reset restores DEFAULT_CODE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_key        <= 4'd13;
            r_buf        <= '0;
            r_code       <= DEFAULT_CODE;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_fails      <= '0;
            r_timer      <= '0;
            r_unlock     <= 1'b0;
            r_locked_out <= 1'b0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_key        <= key_code;
            r_buf        <= w_buf_nxt;
            r_code       <= w_code_nxt;
            r_count      <= w_count_nxt;
            r_ovf        <= w_ovf_nxt;
            r_fails      <= w_fails_nxt;
            r_timer      <= w_timer_nxt;
            r_unlock     <= (w_state_nxt == ST_OPEN) || (w_state_nxt == ST_PROG);
            r_locked_out <= (w_state_nxt == ST_LOCKOUT);
            r_err        <= w_err_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign unlock      = r_unlock;
    assign locked_out  = r_locked_out;
    assign error_pulse = r_err;
    assign prog_done   = r_done;
    assign state_out   = r_state;
    assign digit_count = r_count;
endmodule

// File: tb/tb_safe_lock_controller.sv
// Scoreboard bench for safe_lock_controller: stimulus queues the expected event and its
// cycle when a hash is issued; a negedge monitor pops and compares whenever the DUT reacts.
module tb_safe_lock_controller;
    typedef enum int {EV_NONE = 0, EV_OPEN = 1, EV_ERR = 2, EV_PROG = 3} ev_e;
    typedef struct {
        ev_e ev;
        int  cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_code = 4'd13;
    logic       unlock, locked_out, error_pulse, prog_done;
    logic [2:0] state_out, digit_count;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic prev_unlock = 1'b0;
    exp_t sb[$];

    safe_lock_controller #(
        .CODE_LEN       (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_FAILS      (3),
        .UNLOCK_CYCLES  (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .unlock      (unlock),
        .locked_out  (locked_out),
        .error_pulse (error_pulse),
        .prog_done   (prog_done),
        .state_out   (state_out),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic got(input ev_e ev);
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", int'(ev), int'(EV_NONE));
        end else begin
            e = sb.pop_front();
            check("event_kind", int'(ev), int'(e.ev));
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: unlock rising edge, error_pulse and prog_done are the observable responses.
    always @(negedge clk) begin
        if (rst) begin
            if (unlock && !prev_unlock) got(EV_OPEN);
            if (error_pulse) got(EV_ERR);
            if (prog_done) got(EV_PROG);
        end
        prev_unlock = unlock;
    end

    // Each key is held one cycle followed by one cycle of 13; a hash queues its expected response
    // 'lat' cycles after the drive (3 through CHECK, 2 straight out of PROG).
    task automatic send(input string s, input ev_e exp_ev, input int lat);
        logic [3:0] k;
        byte        ch;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            if (ch == "#") k = 4'd10;
            else if (ch == "*") k = 4'd11;
            else k = 4'(ch - 8'd48);
            @(negedge clk);
            if (k == 4'd10 && exp_ev != EV_NONE) sb.push_back('{exp_ev, cyc + lat});
            key_code = k;
            @(negedge clk);
            key_code = 4'd13;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure(input bit use_lock, output int n);
        int guard;
        guard = 0;
        n = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(use_lock ? locked_out : unlock) && guard < 20);
        while ((use_lock ? locked_out : unlock) && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Called right after an opening code was sent: manual relock with a hash.
    task automatic relock();
        @(negedge clk);
        send("#", EV_NONE, 0);
        check("relock_before", int'(unlock), 1);
        @(negedge clk);
        check("relock_unlock", int'(unlock), 0);
        check("relock_state", int'(state_out), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_unlock", int'(unlock), 0);
        check("rst_locked_out", int'(locked_out), 0);
        check("rst_error_pulse", int'(error_pulse), 0);
        check("rst_prog_done", int'(prog_done), 0);
        check("rst_state", int'(state_out), 0);
        check("rst_digit_count", int'(digit_count), 0);
        rst = 1'b1;
        idle(2);

        // Correct default code, timed relock
        send("1234#", EV_OPEN, 3);
        measure(1'b0, n);
        check("open_hold_cycles", n, 8);
        check("expire_state", int'(state_out), 0);

        // Three wrong codes, lockout ignores a correct code
        idle(2);
        for (int a = 0; a < 3; a++) begin
            send("1235#", EV_ERR, 3);
            if (a < 2) idle(3);
        end
        fork
            measure(1'b1, n);
            begin
                idle(3);
                send("1234#", EV_NONE, 0);
            end
        join
        check("lockout_cycles", n, 16);
        check("lockout_exit_state", int'(state_out), 0);
        idle(1);
        send("1234#", EV_OPEN, 3);
        measure(1'b0, n);
        check("open_after_lockout", n, 8);

        // Overflow, short code, star abort without a counted fail
        idle(2);
        send("12345#", EV_ERR, 3);
        idle(3);
        send("123#", EV_ERR, 3);
        idle(3);
        send("12*", EV_NONE, 0);
        idle(2);
        check("abort_state", int'(state_out), 0);
        send("1234#", EV_OPEN, 3);
        relock();
        check("abort_no_lockout", int'(locked_out), 0);

        // Reprogram to 9876
        idle(2);
        send("1234#", EV_OPEN, 3);
        @(negedge clk);
        send("*9876#", EV_PROG, 2);
        @(negedge clk);
        check("prog_unlock_off", int'(unlock), 0);
        check("prog_exit_state", int'(state_out), 0);
        idle(2);
        send("1234#", EV_ERR, 3);
        idle(3);
        send("9876#", EV_OPEN, 3);
        relock();

        // Failed programming returns to OPEN with a fresh timer, code unchanged
        idle(2);
        send("9876#", EV_OPEN, 3);
        @(negedge clk);
        send("*98#", EV_ERR, 2);
        measure(1'b0, n);
        check("prog_fail_reload", n, 8);
        check("prog_fail_exit_state", int'(state_out), 0);
        idle(2);
        send("9876#", EV_OPEN, 3);
        relock();

        // Asynchronous reset mid-entry
        idle(2);
        send("12", EV_NONE, 0);
        @(negedge clk);
        check("entry_count", int'(digit_count), 2);
        check("entry_state", int'(state_out), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_entry_state", int'(state_out), 0);
        check("arst_entry_count", int'(digit_count), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Asynchronous reset while open on a reprogrammed code restores DEFAULT_CODE
        send("1234#", EV_OPEN, 3);
        @(negedge clk);
        send("*9876#", EV_PROG, 2);
        idle(3);
        send("9876#", EV_OPEN, 3);
        idle(3);
        check("open_before_rst", int'(unlock), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_open_unlock", int'(unlock), 0);
        check("arst_open_state", int'(state_out), 0);
        check("arst_open_locked_out", int'(locked_out), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        send("1234#", EV_OPEN, 3);
        relock();

        idle(10);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
